// File: rtl/sprite_mover_if.sv
// Pixel-write and status bundle between a sprite mover and the VGA adapter side.
// master = the sprite mover, slave = whatever drives enable/dir and consumes pixels.
interface sprite_mover_if;
  logic       enable;
  logic [1:0] dir;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       step_done;

  modport master (
    input  enable, dir,
    output x, y, colour, plot, busy, pos_x, pos_y, step_done
  );

  modport slave (
    output enable, dir,
    input  x, y, colour, plot, busy, pos_x, pos_y, step_done
  );
endinterface

// File: rtl/sprite_mover.sv
// Rectangular sprite animator: erase, move (edge-clamped), redraw once per step event,
// emitting one pixel per clock for the 160x120 adapter write port.
module sprite_mover #(
  parameter int         SPRITE_W        = 4,
  parameter int         SPRITE_H        = 4,
  parameter int         SCREEN_W        = 160,
  parameter int         SCREEN_H        = 120,
  parameter int         START_X         = 10,
  parameter int         START_Y         = 58,
  parameter int         TICKS_PER_FRAME = 833333,
  parameter int         FRAMES_PER_STEP = 15,
  parameter int         STEP_PIX        = 1,
  parameter logic [2:0] SPRITE_COLOUR   = 3'd2,
  parameter logic [2:0] BG_COLOUR       = 3'd0
) (
  input  logic           clock,
  input  logic           resetn,
  sprite_mover_if.master bus
);

  localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [8:0] MAX_X = 9'(SCREEN_W - SPRITE_W);
  localparam logic [7:0] MAX_Y = 8'(SCREEN_H - SPRITE_H);

  typedef enum logic [2:0] {S_INIT, S_DRAW, S_WAIT, S_ERASE, S_UPDATE} state_t;

  state_t        r_state;
  logic [3:0]    r_col;
  logic [3:0]    r_row;
  logic [TW-1:0] r_tick;
  logic [FW-1:0] r_frame;
  logic [7:0]    r_pos_x;
  logic [6:0]    r_pos_y;

  logic       w_frame_tick;
  logic       w_step_event;
  logic       w_last_pixel;
  logic [8:0] w_right_sum;
  logic [8:0] w_left_diff;
  logic [7:0] w_down_sum;
  logic [7:0] w_up_diff;
  logic [7:0] w_next_x;
  logic [6:0] w_next_y;

  assign w_frame_tick = (r_tick == TW'(TICKS_PER_FRAME - 1));
  assign w_step_event = w_frame_tick && (r_frame == FW'(FRAMES_PER_STEP - 1));
  assign w_last_pixel = (r_col == 4'(SPRITE_W - 1)) && (r_row == 4'(SPRITE_H - 1));

  // One extra bit so a left/up underflow shows up as a set MSB instead of wrapping.
  assign w_right_sum = {1'b0, r_pos_x} + 9'(STEP_PIX);
  assign w_left_diff = {1'b0, r_pos_x} - 9'(STEP_PIX);
  assign w_down_sum  = {1'b0, r_pos_y} + 8'(STEP_PIX);
  assign w_up_diff   = {1'b0, r_pos_y} - 8'(STEP_PIX);

  always_comb begin
    w_next_x = r_pos_x;
    w_next_y = r_pos_y;
    case (bus.dir)
      2'b00: w_next_x = (w_right_sum > MAX_X) ? MAX_X[7:0] : w_right_sum[7:0];
      2'b01: w_next_x = w_left_diff[8] ? 8'd0 : w_left_diff[7:0];
      2'b10: w_next_y = (w_down_sum > MAX_Y) ? MAX_Y[6:0] : w_down_sum[6:0];
      default: w_next_y = w_up_diff[7] ? 7'd0 : w_up_diff[6:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_INIT;
      r_col   <= '0;
      r_row   <= '0;
      r_tick  <= '0;
      r_frame <= '0;
      r_pos_x <= 8'(START_X);
      r_pos_y <= 7'(START_Y);
    end else begin
      // Frame timing free-runs regardless of state so step spacing stays fixed.
      r_tick <= w_frame_tick ? '0 : r_tick + 1'b1;
      if (w_frame_tick)
        r_frame <= (r_frame == FW'(FRAMES_PER_STEP - 1)) ? '0 : r_frame + 1'b1;

      case (r_state)
        S_INIT: begin
          r_state <= S_DRAW;
          r_col   <= '0;
          r_row   <= '0;
        end
        S_DRAW, S_ERASE: begin
          if (w_last_pixel) begin
            r_state <= (r_state == S_DRAW) ? S_WAIT : S_UPDATE;
            r_col   <= '0;
            r_row   <= '0;
          end else if (r_col == 4'(SPRITE_W - 1)) begin
            r_col <= '0;
            r_row <= r_row + 4'd1;
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
        S_WAIT: begin
          if (w_step_event && bus.enable) begin
            r_state <= S_ERASE;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        S_UPDATE: begin
          r_pos_x <= w_next_x;
          r_pos_y <= w_next_y;
          r_state <= S_DRAW;
          r_col   <= '0;
          r_row   <= '0;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign bus.x         = r_pos_x + {4'b0, r_col};
  assign bus.y         = r_pos_y + {3'b0, r_row};
  assign bus.plot      = (r_state == S_DRAW) || (r_state == S_ERASE);
  assign bus.colour    = (r_state == S_DRAW) ? SPRITE_COLOUR : BG_COLOUR;
  assign bus.busy      = (r_state != S_WAIT);
  assign bus.pos_x     = r_pos_x;
  assign bus.pos_y     = r_pos_y;
  assign bus.step_done = (r_state == S_DRAW) && w_last_pixel;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench: three sprite movers on a shared clock with short frames, checked
// cycle-by-cycle against hand-computed pixel sequences.
module tb_sprite_mover;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetn0, resetn1, resetn2;
  sprite_mover_if if0 ();
  sprite_mover_if if1 ();
  sprite_mover_if if2 ();

  sprite_mover #(.TICKS_PER_FRAME(4), .FRAMES_PER_STEP(2)) u0 (
    .clock(clock), .resetn(resetn0), .bus(if0));
  sprite_mover #(.TICKS_PER_FRAME(4), .FRAMES_PER_STEP(2), .START_X(155), .STEP_PIX(3)) u1 (
    .clock(clock), .resetn(resetn1), .bus(if1));
  sprite_mover #(.TICKS_PER_FRAME(4), .FRAMES_PER_STEP(2), .START_X(1), .START_Y(2),
                 .STEP_PIX(3)) u2 (
    .clock(clock), .resetn(resetn2), .bus(if2));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int max_x1 = 0;
  int max_px1 = 0;

  always @(negedge clock) begin
    if (resetn1 && if1.plot && int'(if1.x) > max_x1) max_x1 = int'(if1.x);
    if (resetn1 && int'(if1.pos_x) > max_px1) max_px1 = int'(if1.pos_x);
  end

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pix0(input string tag, input int p, input int bx, input int by,
                          input int col);
    chk($sformatf("%s%0d_plot", tag, p), 32'(if0.plot), 1);
    chk($sformatf("%s%0d_colour", tag, p), 32'(if0.colour), col);
    chk($sformatf("%s%0d_x", tag, p), 32'(if0.x), bx + p % 4);
    chk($sformatf("%s%0d_y", tag, p), 32'(if0.y), by + p / 4);
  endtask

  initial begin
    resetn0 = 1'b0; resetn1 = 1'b0; resetn2 = 1'b0;
    if0.enable = 1'b1; if0.dir = 2'b00;
    if1.enable = 1'b1; if1.dir = 2'b00;
    if2.enable = 1'b1; if2.dir = 2'b01;
    repeat (3) tick();

    chk("rst_plot", 32'(if0.plot), 0);
    chk("rst_busy", 32'(if0.busy), 1);
    chk("rst_step_done", 32'(if0.step_done), 0);
    chk("rst_colour", 32'(if0.colour), 0);
    chk("rst_x", 32'(if0.x), 10);
    chk("rst_y", 32'(if0.y), 58);
    chk("rst_pos_x", 32'(if0.pos_x), 10);
    chk("rst_pos_y", 32'(if0.pos_y), 58);
    chk("rst_u1_pos_x", 32'(if1.pos_x), 155);

    resetn0 = 1'b1; resetn1 = 1'b1; resetn2 = 1'b1;
    cyc = 0;

    // Initial draw, cycles 1..16.
    for (int p = 0; p < 16; p++) begin
      tick();
      chk_pix0("draw0_", p, 10, 58, 2);
      chk($sformatf("draw0_sd%0d", p), 32'(if0.step_done), (p == 15) ? 1 : 0);
    end
    tick();
    chk("wait0_busy", 32'(if0.busy), 0);
    chk("wait0_plot", 32'(if0.plot), 0);
    for (int c = 18; c <= 23; c++) begin
      tick();
      chk($sformatf("wait0_plot_c%0d", c), 32'(if0.plot), 0);
    end

    // Step event at cycle 23 -> erase at old position, cycles 24..39.
    for (int p = 0; p < 16; p++) begin
      tick();
      chk_pix0("erase1_", p, 10, 58, 0);
      if (p == 0) begin
        chk("u1_erase1_x", 32'(if1.x), 155);
        chk("u1_erase1_colour", 32'(if1.colour), 0);
      end
    end
    tick();
    chk("update1_plot", 32'(if0.plot), 0);
    chk("update1_busy", 32'(if0.busy), 1);
    chk("update1_pos_x", 32'(if0.pos_x), 10);

    // Redraw at new position, cycles 41..56.
    for (int p = 0; p < 16; p++) begin
      tick();
      chk_pix0("draw1_", p, 11, 58, 2);
      chk($sformatf("draw1_sd%0d", p), 32'(if0.step_done), (p == 15) ? 1 : 0);
      if (p == 0) begin
        chk("move1_pos_x", 32'(if0.pos_x), 11);
        chk("u1_clamp_pos_x", 32'(if1.pos_x), 156);
        chk("u1_clamp_x", 32'(if1.x), 156);
        chk("u2_left_pos_x", 32'(if2.pos_x), 0);
        chk("u2_left_x", 32'(if2.x), 0);
        chk("u2_left_pos_y", 32'(if2.pos_y), 2);
      end
    end

    if0.enable = 1'b0;
    if2.dir = 2'b11;
    // Events at 63 and 71 dropped; enable rises mid-frame at 76, next event is 79.
    for (int c = 57; c <= 79; c++) begin
      tick();
      chk($sformatf("disabled_plot_c%0d", c), 32'(if0.plot), 0);
      if (c == 64) begin
        chk("u1_erase2_plot", 32'(if1.plot), 1);
        chk("u1_erase2_x", 32'(if1.x), 156);
        chk("u1_erase2_colour", 32'(if1.colour), 0);
      end
      if (c == 76) if0.enable = 1'b1;
    end

    for (int p = 0; p < 8; p++) begin
      tick();
      chk_pix0("erase2_", p, 11, 58, 0);
      if (p == 1) begin
        chk("u1_draw2_x", 32'(if1.x), 156);
        chk("u1_draw2_pos_x", 32'(if1.pos_x), 156);
        chk("u2_up_pos_y", 32'(if2.pos_y), 0);
        chk("u2_up_pos_x", 32'(if2.pos_x), 0);
      end
    end
    resetn0 = 1'b0;
    tick();
    chk("midrst_plot", 32'(if0.plot), 0);
    chk("midrst_busy", 32'(if0.busy), 1);
    chk("midrst_pos_x", 32'(if0.pos_x), 10);
    chk("midrst_pos_y", 32'(if0.pos_y), 58);
    chk("midrst_x", 32'(if0.x), 10);
    chk("midrst_y", 32'(if0.y), 58);
    chk("midrst_step_done", 32'(if0.step_done), 0);
    resetn0 = 1'b1;

    for (int p = 0; p < 16; p++) begin
      tick();
      chk_pix0("draw_rst_", p, 10, 58, 2);
      chk($sformatf("draw_rst_sd%0d", p), 32'(if0.step_done), (p == 15) ? 1 : 0);
    end
    tick();
    chk("after_rst_busy", 32'(if0.busy), 0);
    chk("after_rst_plot", 32'(if0.plot), 0);

    chk("u1_max_x", 32'(max_x1), 159);
    chk("u1_max_pos_x", 32'(max_px1), 156);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
